// File: rtl/pipe_adder_pkg.sv
// Shared mode encodings and segment-bound helpers for the pipelined adder.
package pipe_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

    function automatic int seg_hi(input int k, input int seg, input int width);
        return ((((k + 1) * seg) < width) ? ((k + 1) * seg) : width) - 1;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// Combinational N-bit ripple segment; also exposes the carry into its MSB
// so the segment holding bit WIDTH-1 can form signed overflow.
module adder_seg #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    always_comb begin
        logic c;
        c        = cin;
        sum      = '0;
        c_msb_in = cin;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) c_msb_in = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-chain adder/subtractor, STAGES registered segments, valid/ready.
// Optional unsigned saturation on a per-operation basis with PIPE_ADDER_SAT_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
`ifdef PIPE_ADDER_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    logic                          advance;
    logic [STAGES-1:0]             valid_q, valid_in;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, sum_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_in, b_in, sum_in, sum_d, sum_next;
    logic [STAGES-1:0]             carry_q, carry_in, carry_d;
    logic [STAGES-1:0]             ovf_q, ovf_in, ovf_d;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q, tag_in;
`ifdef PIPE_ADDER_SAT_EN
    logic [STAGES-1:0]             sub_q, sub_in, sat_q, sat_in;
`endif

    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance && !flush;

    // Stage 0 sees the operation; subtract is A + ~B + 1.
    assign valid_in[0] = in_valid;
    assign a_in[0]     = in_a;
    assign b_in[0]     = (in_sub == MODE_ADD) ? in_b : ~in_b;
    assign carry_in[0] = (in_sub == MODE_SUB) ? 1'b1 : in_cin;
    assign sum_in[0]   = '0;
    assign ovf_in[0]   = 1'b0;
    assign tag_in[0]   = in_tag;
`ifdef PIPE_ADDER_SAT_EN
    assign sub_in[0]   = in_sub;
    assign sat_in[0]   = in_sat;
`endif

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign valid_in[k] = valid_q[k-1];
        assign a_in[k]     = a_q[k-1];
        assign b_in[k]     = b_q[k-1];
        assign carry_in[k] = carry_q[k-1];
        assign sum_in[k]   = sum_q[k-1];
        assign ovf_in[k]   = ovf_q[k-1];
        assign tag_in[k]   = tag_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
        assign sub_in[k]   = sub_q[k-1];
        assign sat_in[k]   = sat_q[k-1];
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, SEG);
        if (LO < WIDTH) begin : g_seg
            localparam int HI = seg_hi(k, SEG, WIDTH);
            localparam int N  = HI - LO + 1;
            localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << N) - WIDTH'(1)) << LO;
            logic [N-1:0] seg_sum;
            logic         seg_cout, seg_c_msb;

            adder_seg #(.N(N)) u_seg (
                .a        (a_in[k][HI:LO]),
                .b        (b_in[k][HI:LO]),
                .cin      (carry_in[k]),
                .sum      (seg_sum),
                .cout     (seg_cout),
                .c_msb_in (seg_c_msb)
            );

            assign sum_d[k]   = (sum_in[k] & ~MASK) | (WIDTH'(seg_sum) << LO);
            assign carry_d[k] = seg_cout;
            if (HI == WIDTH - 1) begin : g_msb
                assign ovf_d[k] = seg_c_msb ^ seg_cout;
            end else begin : g_mid
                assign ovf_d[k] = ovf_in[k];
            end
        end else begin : g_pass
            // Segment lies beyond WIDTH: pure delay so latency stays STAGES.
            assign sum_d[k]   = sum_in[k];
            assign carry_d[k] = carry_in[k];
            assign ovf_d[k]   = ovf_in[k];
        end
    end

    always_comb begin
        sum_next = sum_d;
`ifdef PIPE_ADDER_SAT_EN
        if (sat_in[LAST]) begin
            if (sub_in[LAST] == MODE_ADD && carry_d[LAST]) begin
                sum_next[LAST] = '1;
            end else if (sub_in[LAST] == MODE_SUB && !carry_d[LAST]) begin
                sum_next[LAST] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            tag_q   <= '0;
`ifdef PIPE_ADDER_SAT_EN
            sub_q   <= '0;
            sat_q   <= '0;
`endif
        end else if (flush) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_in;
            a_q     <= a_in;
            b_q     <= b_in;
            sum_q   <= sum_next;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            tag_q   <= tag_in;
`ifdef PIPE_ADDER_SAT_EN
            sub_q   <= sub_in;
            sat_q   <= sat_in;
`endif
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_cout  = carry_q[LAST];
    assign out_ovf   = ovf_q[LAST];
    assign out_tag   = tag_q[LAST];

endmodule
